counterup16_ctrl: RTL

Run-control sequencer for a 16-bit up counter datapath. Accepts start/stop/clear commands and a terminal value from a host or scheduler, steps the counter through an IDLE/RUN/PAUSE/DONE state machine, and reports completion with a single-cycle `done` pulse. It sits between control logic and the free-running counter slice, turning it into a bounded, restartable timer.

---
 rtl/counterup16_ctrl_pkg.sv | 14 +
 rtl/counterup16_ctrl_if.sv | 28 ++
 rtl/counterup16_ctrl_core.sv | 25 ++
 rtl/counterup16_ctrl.sv | 119 +++++++++++
 4 files changed

// File: rtl/counterup16_ctrl_pkg.sv
// Shared types and constants for the counterup16 run-control block:
// FSM state encoding and the default counter width.
package counterup16_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/counterup16_ctrl_if.sv
// Command/status bundle between a host or scheduler (master) and the
// counterup16 run-control sequencer (slave).
interface counterup16_ctrl_if
  import counterup16_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             start;
  logic             stop;
  logic             clear;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  state_e           state;

  modport master (
    output start, stop, clear, limit,
    input  count, busy, done, state
  );

  modport slave (
    input  start, stop, clear, limit,
    output count, busy, done, state
  );

endinterface

// File: rtl/counterup16_ctrl_core.sv
// Datapath register of the counterup16 timer: synchronous clear has
// priority over increment, otherwise the value holds.
module counterup16_core #(
  parameter int WIDTH = 16
) (
  input  logic             clock0,
  input  logic             resetn,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge clock0 or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/counterup16_ctrl.sv
// Run-control sequencer (IDLE/RUN/PAUSE/DONE) around a 16-bit up counter.
// Define COUNTERUP16_CTRL_AUTORELOAD_EN for free-running periodic mode.
module counterup16_ctrl
  import counterup16_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic          clock0,
  input  logic          resetn,
  counterup16_ctrl_if.slave bus
);

`ifdef COUNTERUP16_CTRL_AUTORELOAD_EN
  localparam bit AUTORELOAD = 1'b1;
`else
  localparam bit AUTORELOAD = 1'b0;
`endif

  state_e           state_q;
  state_e           state_nxt;
  logic [WIDTH-1:0] limit_q;
  logic [WIDTH-1:0] count_w;
  logic             done_q;
  logic             busy_q;

  logic             at_limit;
  logic             cnt_clr;
  logic             cnt_en;
  logic             load_limit;
  logic             done_nxt;
  logic             busy_nxt;

  assign at_limit = (count_w == limit_q);

  always_ff @(posedge clock0 or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Priority is clear > stop > start; stop only matters in RUN.
  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) state_nxt = RUN;
      end
      RUN: begin
        if (bus.stop) begin
          state_nxt = PAUSE;
        end else if (at_limit) begin
          state_nxt = AUTORELOAD ? RUN : DONE;
        end
      end
      PAUSE: begin
        if (bus.start) state_nxt = RUN;
      end
    endcase
    if (bus.clear) state_nxt = IDLE;
  end

  always_comb begin
    load_limit = 1'b0;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    done_nxt   = 1'b0;
    if (bus.clear) begin
      cnt_clr = 1'b1;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          load_limit = bus.start;
          cnt_clr    = bus.start;
        end
        RUN: begin
          if (!bus.stop) begin
            done_nxt = at_limit;
            cnt_en   = !at_limit;
            cnt_clr  = at_limit && AUTORELOAD;
          end
        end
        PAUSE: begin
          cnt_en = 1'b0;
        end
      endcase
    end
    busy_nxt = (state_nxt == RUN) || (state_nxt == PAUSE);
  end

  always_ff @(posedge clock0 or negedge resetn) begin
    if (!resetn) begin
      limit_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      if (load_limit) limit_q <= bus.limit;
      done_q <= done_nxt;
      busy_q <= busy_nxt;
    end
  end

  counterup16_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clock0 (clock0),
    .resetn (resetn),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .count  (count_w)
  );

  assign bus.count = count_w;
  assign bus.state = state_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule
